// File: rtl/main_memory_responder_if.sv
// Request/response bundle between the cache (master) and the backing memory (slave).
// Also carries the responder's read/write request counters.
interface main_memory_responder_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned BLOCK_SIZE = 16
);
  localparam int unsigned BW = ADDR_WIDTH - $clog2(BLOCK_SIZE);
  localparam int unsigned DW = BLOCK_SIZE * 8;

  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [BW-1:0] req_block_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_rdata;
  logic          resp_write;
  logic          resp_err;
  logic [31:0]   total_reads;
  logic [31:0]   total_writes;

  modport master (
    output req_valid, req_write, req_block_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_write, resp_err,
           total_reads, total_writes
  );

  modport slave (
    input  req_valid, req_write, req_block_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_write, resp_err,
           total_reads, total_writes
  );
endinterface

// File: rtl/main_memory_responder.sv
// Block-granular backing memory behind the cache: one request at a time,
// fixed read/write latency, a single held response, and request counters.
module main_memory_responder #(
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned BLOCK_SIZE    = 16,
  parameter int unsigned MEM_BLOCKS    = 256,
  parameter int unsigned READ_LATENCY  = 4,
  parameter int unsigned WRITE_LATENCY = 2
) (
  input logic                  clk,
  input logic                  reset,
  main_memory_responder_if.slave bus
);
  localparam int unsigned BW      = ADDR_WIDTH - $clog2(BLOCK_SIZE);
  localparam int unsigned DW      = BLOCK_SIZE * 8;
  localparam int unsigned IW      = (MEM_BLOCKS > 1) ? $clog2(MEM_BLOCKS) : 1;
  localparam int unsigned MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int unsigned LW      = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          write_q, write_d;
  logic          req_ready_q, req_ready_d;
  logic          resp_valid_q, resp_valid_d;
  logic [DW-1:0] resp_rdata_q, resp_rdata_d;
  logic          resp_write_q, resp_write_d;
  logic          resp_err_q, resp_err_d;
  logic [31:0]   reads_q, reads_d;
  logic [31:0]   writes_q, writes_d;

  logic [DW-1:0] mem_q [MEM_BLOCKS];
  logic          in_range_c;
  logic [IW-1:0] mem_idx_c;
  logic          mem_we_c;

  assign in_range_c = (32'(addr_q) < MEM_BLOCKS);
  assign mem_idx_c  = addr_q[IW-1:0];

  // Next-state and response generation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_write_d = resp_write_q;
    resp_err_d   = resp_err_q;
    reads_d      = reads_q;
    writes_d     = writes_q;
    mem_we_c     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d      = bus.req_block_addr;
          wdata_d     = bus.req_wdata;
          write_d     = bus.req_write;
          req_ready_d = 1'b0;
          state_d     = BUSY;
          if (bus.req_write) begin
            cnt_d    = LW'(WRITE_LATENCY - 1);
            writes_d = writes_q + 32'd1;
          end else begin
            cnt_d   = LW'(READ_LATENCY - 1);
            reads_d = reads_q + 32'd1;
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          resp_valid_d = 1'b1;
          resp_write_d = write_q;
          resp_err_d   = ~in_range_c;
          resp_rdata_d = (!write_q && in_range_c) ? mem_q[mem_idx_c] : '0;
          mem_we_c     = write_q && in_range_c && !reset;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - LW'(1);
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          resp_rdata_d = '0;
          req_ready_d  = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_write_q <= 1'b0;
      resp_err_q   <= 1'b0;
      reads_q      <= '0;
      writes_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_write_q <= resp_write_d;
      resp_err_q   <= resp_err_d;
      reads_q      <= reads_d;
      writes_q     <= writes_d;
    end
  end

  // Storage is never cleared; a reset during BUSY suppresses the commit via mem_we_c
  always_ff @(posedge clk) begin
    if (mem_we_c) mem_q[mem_idx_c] <= wdata_q;
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_rdata   = resp_rdata_q;
  assign bus.resp_write   = resp_write_q;
  assign bus.resp_err     = resp_err_q;
  assign bus.total_reads  = reads_q;
  assign bus.total_writes = writes_q;
endmodule
